// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// reset-cause bit positions and a width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int CAUSE_LOCK = 0;
    localparam int CAUSE_BTN  = 1;
    localparam int CAUSE_WD   = 2;
    localparam int CAUSE_SW   = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Reset request / reset result bundle between the board-level sources and the
// sequencer. The sequencer side is the slave; whoever drives the requests is the master.
interface rst_seq_if;

    // No valid/ready pairing here: every request is a level sampled on each
    // clk edge, and the outputs are registered levels that are always valid.
    logic       clk_ok;
    logic       btn_rst_n;
    logic       wd_rst;
    logic       sys_rst_req;
    logic       rst_out_n;
    logic [3:0] rst_cause;
    logic [7:0] lock_loss_cnt;

    modport master (
        output clk_ok,
        output btn_rst_n,
        output wd_rst,
        output sys_rst_req,
        input  rst_out_n,
        input  rst_cause,
        input  lock_loss_cnt
    );

    modport slave (
        input  clk_ok,
        input  btn_rst_n,
        input  wd_rst,
        input  sys_rst_req,
        output rst_out_n,
        output rst_cause,
        output lock_loss_cnt
    );

endinterface

// File: rtl/rst_seq_debounce.sv
// Button conditioner: 2-flop synchroniser on the active-low button, then a
// debouncer whose output 'pressed' only moves after DEB_CYCLES stable cycles.
module debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] cnt_q;
    logic          raw_pressed;

    assign raw_pressed = ~sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            pressed <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_n};
            // Any cycle agreeing with the current output restarts the run.
            if (raw_pressed == pressed) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                pressed <= raw_pressed;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: qualifies PLL lock, merges button/watchdog/software requests
// and releases the system reset synchronously; latches why the last reset happened.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int LOCK_STABLE = 1024,
    parameter int HOLD_CYCLES = 64,
    parameter int DEB_CYCLES  = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    rst_seq_if.slave     bus,
    output state_t       state_dbg
);

    localparam int CW = $clog2(max_int(LOCK_STABLE, HOLD_CYCLES) + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lock_sync_q;
    logic          lock_s;
    logic          btn_p;
    logic          src_req;
    logic          rst_out_q, rst_out_d;
    logic [3:0]    cause_q, cause_d;
    logic [7:0]    loss_q, loss_d;

    assign lock_s  = lock_sync_q[1];
    assign src_req = btn_p | bus.wd_rst | bus.sys_rst_req;

    debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n   (bus.btn_rst_n),
        .pressed (btn_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= 2'b00;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            rst_out_q   <= 1'b0;
            cause_q     <= 4'b0001;
            loss_q      <= 8'd0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], bus.clk_ok};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_q   <= rst_out_d;
            cause_q     <= cause_d;
            loss_q      <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (src_req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                // Losing lock outranks every other source.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (src_req) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rst_out_d = (state_d == RUN);
        cause_d   = cause_q;
        loss_d    = loss_q;
        if (state_q == RUN && state_d != RUN) begin
            cause_d[CAUSE_LOCK] = ~lock_s;
            cause_d[CAUSE_BTN]  = btn_p;
            cause_d[CAUSE_WD]   = bus.wd_rst;
            cause_d[CAUSE_SW]   = bus.sys_rst_req;
        end
        if (state_q == RUN && state_d == WAIT_LOCK && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
        end
    end

    assign bus.rst_out_n     = rst_out_q;
    assign bus.rst_cause     = cause_q;
    assign bus.lock_loss_cnt = loss_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq with short lock/hold/debounce parameters.
module tb_rst_seq;
    import rst_seq_pkg::*;

    localparam int LS     = 8;
    localparam int HC     = 16;
    localparam int DEB    = 4;
    localparam int WD_LEN = 10;
    localparam int PRESS  = 10;

    logic   clk;
    logic   rst_n;
    state_t state_dbg;
    int     checks;
    int     failures;
    logic [3:0] exp_q[$];

    rst_seq_if bus_if ();

    rst_seq #(
        .LOCK_STABLE (LS),
        .HOLD_CYCLES (HC),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // checking and driver tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_level(input logic lvl, input int max, output int n);
        n = 0;
        while (bus_if.rst_out_n !== lvl && n < max) begin
            tick(1);
            n++;
        end
    endtask

    task automatic sb_pop_cause(input string tag);
        logic [3:0] e;
        check({tag, "_sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 32'(bus_if.rst_cause), 32'(e));
        end
    endtask

    initial begin
        int n;
        int m;
        int lows;
        checks   = 0;
        failures = 0;
        rst_n                = 1'b0;
        bus_if.clk_ok        = 1'b0;
        bus_if.btn_rst_n     = 1'b1;
        bus_if.wd_rst        = 1'b0;
        bus_if.sys_rst_req   = 1'b0;
        tick(3);
        check("reset_rst_out", 32'(bus_if.rst_out_n), 32'd0);
        check("reset_cause", 32'(bus_if.rst_cause), 32'h1);
        check("reset_loss", 32'(bus_if.lock_loss_cnt), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(WAIT_LOCK));
        rst_n = 1'b1;
        tick(3);
        check("nolock_rst_out", 32'(bus_if.rst_out_n), 32'd0);

        // power-up: first sampling edge counts as edge 1
        bus_if.clk_ok = 1'b1;
        wait_level(1'b1, 100, n);
        check("pwr_rise_edges", 32'(n), 32'(2 + LS + HC));
        check("pwr_cause", 32'(bus_if.rst_cause), 32'h1);
        check("pwr_state", 32'(state_dbg), 32'(RUN));

        // software restart
        bus_if.sys_rst_req = 1'b1;
        exp_q.push_back(4'b1000);
        tick(1);
        bus_if.sys_rst_req = 1'b0;
        check("sw_fall", 32'(bus_if.rst_out_n), 32'd0);
        sb_pop_cause("sw_cause");
        wait_level(1'b1, 100, n);
        check("sw_low_cycles", 32'(n), 32'(HC));

        // watchdog and software in the same cycle
        bus_if.wd_rst      = 1'b1;
        bus_if.sys_rst_req = 1'b1;
        exp_q.push_back(4'b1100);
        tick(1);
        bus_if.wd_rst      = 1'b0;
        bus_if.sys_rst_req = 1'b0;
        check("dual_fall", 32'(bus_if.rst_out_n), 32'd0);
        sb_pop_cause("dual_cause");
        wait_level(1'b1, 100, n);
        check("dual_low_cycles", 32'(n), 32'(HC));

        // held watchdog extends HOLD: rise on edge WD_LEN+HC counting the first wd edge
        bus_if.wd_rst = 1'b1;
        exp_q.push_back(4'b0100);
        tick(1);
        check("wd_fall", 32'(bus_if.rst_out_n), 32'd0);
        sb_pop_cause("wd_cause");
        tick(WD_LEN - 1);
        bus_if.wd_rst = 1'b0;
        check("wd_still_low", 32'(bus_if.rst_out_n), 32'd0);
        wait_level(1'b1, 100, n);
        check("wd_rise_edges", 32'(WD_LEN + n), 32'(WD_LEN + HC));

        // bouncing button must not reset
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            bus_if.btn_rst_n = ~bus_if.btn_rst_n;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (bus_if.rst_out_n !== 1'b1) lows++;
            end
        end
        check("bounce_no_rst", 32'(lows), 32'd0);

        // stable press: 2 sync + DEB debounce + 1 state edge
        bus_if.btn_rst_n = 1'b0;
        exp_q.push_back(4'b0010);
        wait_level(1'b0, PRESS, n);
        check("btn_fall_edges", 32'(n), 32'(2 + DEB + 1));
        sb_pop_cause("btn_cause");
        tick(PRESS - n);
        bus_if.btn_rst_n = 1'b1;
        wait_level(1'b1, 100, m);
        check("btn_rise_edges", 32'(PRESS + m), 32'(PRESS + 2 + DEB + HC));

        // rst_n in the middle of HOLD
        bus_if.sys_rst_req = 1'b1;
        exp_q.push_back(4'b1000);
        tick(1);
        bus_if.sys_rst_req = 1'b0;
        sb_pop_cause("sw2_cause");
        tick(3);
        check("midhold_state", 32'(state_dbg), 32'(HOLD));
        bus_if.clk_ok = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midhold_rst_out", 32'(bus_if.rst_out_n), 32'd0);
        check("midhold_state_rst", 32'(state_dbg), 32'(WAIT_LOCK));
        check("midhold_cause_rst", 32'(bus_if.rst_cause), 32'h1);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // lock glitch after 5 stable cycles restarts the lock count
        bus_if.clk_ok = 1'b1;
        tick(5);
        check("glitch_pre_state", 32'(state_dbg), 32'(WAIT_LOCK));
        bus_if.clk_ok = 1'b0;
        tick(1);
        bus_if.clk_ok = 1'b1;
        wait_level(1'b1, 100, n);
        check("glitch_rise_edges", 32'(n), 32'(2 + LS + HC));

        // repeated lock loss in RUN
        for (int i = 0; i < 300; i++) begin
            bus_if.clk_ok = 1'b0;
            exp_q.push_back(4'b0001);
            tick(2);
            check("loss_pre_fall", 32'(bus_if.rst_out_n), 32'd1);
            tick(1);
            check("loss_fall", 32'(bus_if.rst_out_n), 32'd0);
            sb_pop_cause("loss_cause");
            check("loss_cnt", 32'(bus_if.lock_loss_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
            bus_if.clk_ok = 1'b1;
            wait_level(1'b1, 100, n);
            check("loss_rise_edges", 32'(n), 32'(2 + LS + HC));
        end

        // rst_n in RUN clears the loss counter
        #1 rst_n = 1'b0;
        #1;
        check("clr_loss", 32'(bus_if.lock_loss_cnt), 32'd0);
        check("clr_rst_out", 32'(bus_if.rst_out_n), 32'd0);
        check("clr_cause", 32'(bus_if.rst_cause), 32'h1);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
